// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the LFSR word arbiter.
// FSM encoding, default LFSR geometry, XNOR feedback and lock-up value.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } arb_state_e;

  localparam int unsigned LFSR_N = 10;
  localparam logic [LFSR_N-1:0] LFSR_TAPS = 10'h240;

  function automatic logic xnor_fb(
    input logic [31:0] state,
    input logic [31:0] taps
  );
    return ~^(state & taps);
  endfunction

  function automatic logic [31:0] lockup(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/lfsr_step_engine.sv
// lfsr_step_engine: XNOR Fibonacci LFSR with a single-step enable.
// Load has priority over step; state shifts toward the MSB.
module lfsr_step_engine
  import lfsr_pkg::*;
#(
  parameter int N = LFSR_N,
  parameter logic [N-1:0] TAPS = LFSR_TAPS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_en,
  input  logic         load_en,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] state
);

  logic w_fb;

  assign w_fb = xnor_fb(32'(state), 32'(TAPS));

  // state register: load wins, otherwise one step when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load_en) begin
      state <= load_val;
    end else if (step_en) begin
      state <= {state[N-2:0], w_fb};
    end
  end

endmodule

// File: rtl/lfsr_word_arb.sv
// lfsr_word_arb: round-robin server of W-bit LFSR words to NREQ requesters.
// Define LFSR_WORD_ARB_STATS_EN to add the saturating gnt_count output.
module lfsr_word_arb
  import lfsr_pkg::*;
#(
  parameter int N = LFSR_N,
  parameter logic [N-1:0] TAPS = LFSR_TAPS,
  parameter int W = 8,
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [W-1:0]    data_out,
  output logic            data_valid,
  input  logic            seed_load,
  input  logic [N-1:0]    seed,
  output logic            seed_err,
`ifdef LFSR_WORD_ARB_STATS_EN
  output logic [15:0]     gnt_count,
`endif
  output logic            busy
);

  localparam int CW = $clog2(W + 1);
  localparam int PW = $clog2(NREQ);
  localparam logic [N-1:0] LOCK = N'(lockup(N));

  arb_state_e     r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]   r_word, w_word_nxt;
  logic [PW-1:0]  r_ptr, w_ptr_nxt;
  logic [N-1:0]   w_lfsr;
  logic [N-1:0]   w_load_val;
  logic           w_lock;
  logic           w_step;
  logic           w_grant;
  logic           w_found;
  logic [PW-1:0]  w_k;
  logic [PW-1:0]  w_idx;
  logic [NREQ-1:0] w_gnt_oh;

  assign w_lock     = (seed == LOCK);
  assign w_load_val = w_lock ? '0 : seed;

  lfsr_step_engine #(
    .N    (N),
    .TAPS (TAPS)
  ) u_eng (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_en  (w_step),
    .load_en  (seed_load),
    .load_val (w_load_val),
    .state    (w_lfsr)
  );

  // round-robin scan: first asserted req from r_ptr upward
  always_comb begin
    w_found  = 1'b0;
    w_k      = '0;
    w_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_k     = w_idx;
      end
    end
    w_gnt_oh = NREQ'(1) << w_k;
  end

  // next-state, word assembly and grant decision
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_ptr_nxt   = r_ptr;
    w_grant     = 1'b0;
    w_step      = 1'b0;
    if (seed_load) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_word_nxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|req) w_state_nxt = FILL;
        end
        FILL: begin
          w_step     = 1'b1;
          w_word_nxt = W'({r_word, w_lfsr[N-1]});
          if (r_cnt == CW'(W - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = READY;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        READY: begin
          if (w_found) begin
            w_grant   = 1'b1;
            w_ptr_nxt = (w_k == PW'(NREQ - 1)) ? '0 : w_k + PW'(1);
            w_state_nxt = |(req & ~w_gnt_oh) ? FILL : IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_word     <= '0;
      r_ptr      <= '0;
      gnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      seed_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_word     <= w_word_nxt;
      r_ptr      <= w_ptr_nxt;
      gnt        <= w_grant ? w_gnt_oh : '0;
      data_out   <= w_grant ? r_word : '0;
      data_valid <= w_grant;
      seed_err   <= seed_load & w_lock;
      busy       <= (w_state_nxt != IDLE);
    end
  end

`ifdef LFSR_WORD_ARB_STATS_EN
  logic [15:0] r_gnt_count;

  assign gnt_count = r_gnt_count;

  // saturating grant counter, untouched by seed_load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_count <= '0;
    end else if (w_grant && r_gnt_count != 16'hFFFF) begin
      r_gnt_count <= r_gnt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_word_arb.sv
// tb_lfsr_word_arb: directed and random stimulus for lfsr_word_arb.
// Outputs are compared every cycle against a word-level reference model.
module tb_lfsr_word_arb;

  localparam int N = 10;
  localparam int W = 8;
  localparam int NREQ = 4;
  localparam int unsigned TAPS = 32'h240;
  localparam int unsigned MASK = 32'h3FF;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    data_out;
  logic            data_valid;
  logic            seed_load;
  logic [N-1:0]    seed;
  logic            seed_err;
  logic            busy;
`ifdef LFSR_WORD_ARB_STATS_EN
  logic [15:0]     gnt_count;
`endif

  lfsr_word_arb #(
    .N    (N),
    .TAPS (10'h240),
    .W    (W),
    .NREQ (NREQ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .data_out   (data_out),
    .data_valid (data_valid),
    .seed_load  (seed_load),
    .seed       (seed),
    .seed_err   (seed_err),
`ifdef LFSR_WORD_ARB_STATS_EN
    .gnt_count  (gnt_count),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // W LFSR steps from s_in: returns the packed word and the new state
  function automatic void gen_word(
    input  int unsigned s_in,
    output int unsigned word,
    output int unsigned s_out
  );
    int unsigned s;
    int unsigned fb;
    s = s_in;
    word = 0;
    for (int i = 0; i < W; i++) begin
      word = (word << 1) | ((s >> (N - 1)) & 1);
      fb = ($countones(s & TAPS) % 2 == 0) ? 1 : 0;
      s = ((s << 1) | fb) & MASK;
    end
    s_out = s;
  endfunction

  // reference model: word computed up front, fill is a cycle countdown
  int unsigned m_lfsr = 0;
  int unsigned m_word = 0;
  int          m_fill = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  int          m_k;
  bit          m_have = 1'b0;
  logic [NREQ-1:0] e_gnt = '0;
  logic [W-1:0]    e_dout = '0;
  logic            e_dv = 1'b0;
  logic            e_serr = 1'b0;
  logic            e_busy = 1'b0;

  function automatic void start_fill();
    gen_word(m_lfsr, m_word, m_lfsr);
    m_fill = W;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_lfsr = 0; m_word = 0; m_fill = 0;
      m_ptr = 0; m_cnt = 0; m_have = 1'b0;
      e_gnt = '0; e_dout = '0; e_dv = 1'b0;
      e_serr = 1'b0; e_busy = 1'b0;
    end else begin
      e_gnt = '0; e_dv = 1'b0; e_serr = 1'b0;
      if (seed_load) begin
        e_serr = (seed == 10'h3FF);
        m_lfsr = e_serr ? 0 : 32'(seed);
        m_fill = 0;
        m_have = 1'b0;
      end else if (m_have) begin
        m_k = -1;
        for (int i = 0; i < NREQ; i++)
          if (m_k < 0 && req[(m_ptr + i) % NREQ])
            m_k = (m_ptr + i) % NREQ;
        if (m_k >= 0) begin
          e_gnt[m_k] = 1'b1;
          e_dv = 1'b1;
          e_dout = W'(m_word);
          m_ptr = (m_k + 1) % NREQ;
          m_have = 1'b0;
          if (m_cnt < 65535) m_cnt++;
          if ((req & ~e_gnt) != 0) start_fill();
        end
      end else if (m_fill > 0) begin
        m_fill--;
        if (m_fill == 0) m_have = 1'b1;
      end else if (req != 0) begin
        start_fill();
      end
      e_busy = m_have || (m_fill > 0);
    end
  end

  // per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("valid", 32'(data_valid), 32'(e_dv));
      if (e_dv) check("data", 32'(data_out), 32'(e_dout));
      check("seed_err", 32'(seed_err), 32'(e_serr));
      check("busy", 32'(busy), 32'(e_busy));
`ifdef LFSR_WORD_ARB_STATS_EN
      check("gnt_count", 32'(gnt_count), 32'(m_cnt));
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    req = '0;
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < max);
    check("gnt_seen", 32'(gnt != '0), 32'd1);
  endtask

  int n;
  int unsigned w_exp, s_dummy, snap;

  initial begin
    rst_n = 1'b0;
    req = '0;
    seed_load = 1'b0;
    seed = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);

    // single requester held
    req = 4'b0001;
    wait_gnt(30, n);
    check("lat0", 32'(n), 32'(W + 2));
    check("g0", 32'(gnt), 32'h1);
    check("w0", 32'(data_out), 32'h00);
    wait_gnt(30, n);
    check("gap_single", 32'(n), 32'(W + 2));
    check("w1", 32'(data_out), 32'h3F);
    req = '0;

    // all requesters held: rotating one-hot grants
    do_reset();
    req = 4'hF;
    wait_gnt(30, n);
    check("rr_g0", 32'(gnt), 32'h1);
    for (int j = 1; j < 5; j++) begin
      wait_gnt(30, n);
      check("rr_gap", 32'(n), 32'(W + 1));
      check("rr_g", 32'(gnt), 32'(1 << (j % NREQ)));
      check("rr_valid", 32'(data_valid), 32'd1);
    end
    req = '0;

    // lock-up seed replaced by zero
    do_reset();
    seed = 10'h3FF;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("lock_err", 32'(seed_err), 32'd1);
    req = 4'b0100;
    wait_gnt(30, n);
    gen_word(0, w_exp, s_dummy);
    check("lock_word", 32'(data_out), w_exp);
    req = '0;

    // seed_load in the 4th fill cycle aborts that fill
    repeat (2) @(negedge clk);
    req = 4'b0100;
    repeat (4) @(negedge clk);
    seed = 10'h155;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    wait_gnt(30, n);
    check("abort_lat", 32'(n), 32'(W + 2));
    gen_word(32'h155, w_exp, s_dummy);
    check("abort_word", 32'(data_out), w_exp);
    req = '0;

    // dropped request: word waits in READY
    repeat (2) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (15) @(negedge clk);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_gnt", 32'(gnt), 32'd0);
    snap = m_word;
    req = 4'b1000;
    @(negedge clk);
    check("late_gnt", 32'(gnt), 32'h8);
    check("late_word", 32'(data_out), snap);
    req = '0;

`ifdef LFSR_WORD_ARB_STATS_EN
    do_reset();
    req = 4'hF;
    for (int j = 0; j < 5; j++) wait_gnt(30, n);
    req = '0;
    check("cnt5", 32'(gnt_count), 32'd5);
    seed = 10'h2A;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("cnt_seed", 32'(gnt_count), 32'd5);
    req = 4'b0001;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("cnt_rst", 32'(gnt_count), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    req = '0;
`endif

    // random requesters, seeds and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 750 == 400) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        continue;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 99) < 2) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 99) < 10) req[i] = 1'b1;
      end
      if (seed_load) begin
        seed_load = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        seed_load = 1'b1;
        seed = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
      end
    end
    req = '0;
    seed_load = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
